// File: rtl/mem_lsu_stage_pkg.sv
// Shared pipeline types for the Orion core: load/store funct3 codes, LSU FSM states,
// LSU exception causes and the EX/MEM, MEM/WB and MEM->ID forwarding records.
package orion_types;

  localparam int XLEN  = 32;
  localparam int ADDRW = 32;

  localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LS_D  = 3'b011;
  localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LS_HU = 3'b101;
  localparam logic [2:0] FUNCT3_LS_WU = 3'b110;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT
  } lsu_state_e;

  typedef enum logic [1:0] {
    EXC_LD_MISALIGN = 2'd0,
    EXC_ST_MISALIGN = 2'd1,
    EXC_LD_FAULT    = 2'd2,
    EXC_ST_FAULT    = 2'd3
  } lsu_exc_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } debug_t;

  typedef struct packed {
    logic            valid;
    logic            is_load;
    logic            is_store;
    logic [2:0]      ld_str_type;
    logic [XLEN-1:0] rd_v;
    logic [XLEN-1:0] rs2_v;
    logic [4:0]      rd_s;
    logic            rd_we;
    debug_t          debug;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_s;
    logic            rd_we;
    logic [XLEN-1:0] rd_v;
    debug_t          debug;
  } mem_wb_t;

  typedef struct packed {
    logic            valid;
    logic            rd_we;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] rd_v;
  } mem_id_t;

  // Cause encoding: bit 1 = bus fault (vs misalignment), bit 0 = store (vs load).
  function automatic lsu_exc_e lsuCause(input logic isLoad, input logic fault);
    return lsu_exc_e'({fault, ~isLoad});
  endfunction

endpackage

// File: rtl/mem_lsu_stage_align.sv
// Combinational lane logic for the LSU: load extract/extend, store byte enables and
// replicated store data, plus the natural-alignment check.
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  funct3_i,
  input  logic [$clog2(XLEN/8)-1:0]   lane_i,
  input  logic [XLEN-1:0]             rdata_i,
  input  logic [XLEN-1:0]             stData_i,
  output logic [XLEN-1:0]             ldData_o,
  output logic [XLEN-1:0]             wdata_o,
  output logic [XLEN/8-1:0]           be_o,
  output logic                        misaligned_o
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  logic [1:0]      sizeLog;
  logic [XLEN-1:0] shifted;
  logic            signBit;
  logic            extBit;
  int              nBytes;
  int              laneI;

  // Sizes wider than the bus are decode-impossible; clamp so indexing stays in range.
  always_comb begin
    sizeLog = funct3_i[1:0];
    if (int'(funct3_i[1:0]) > LW) begin
      sizeLog = 2'(LW);
    end
    nBytes       = 1 << int'(sizeLog);
    laneI        = int'(lane_i);
    misaligned_o = (laneI & (nBytes - 1)) != 0;
    shifted      = rdata_i >> {lane_i, 3'b000};

    signBit = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b == nBytes - 1) begin
        signBit = shifted[8*b+7];
      end
    end
    extBit = signBit & ~funct3_i[2];

    ldData_o = '0;
    wdata_o  = '0;
    be_o     = '0;
    for (int b = 0; b < NB; b++) begin
      ldData_o[8*b +: 8] = (b < nBytes) ? shifted[8*b +: 8] : {8{extBit}};
      be_o[b]            = (b >= laneI) && (b < laneI + nBytes);
      for (int k = 0; k < NB; k++) begin
        if (k == (b & (nBytes - 1))) begin
          wdata_o[8*b +: 8] = stData_i[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// Memory stage: issues one load/store at a time over a req/gnt/rvalid bus, stalls the
// pipeline while it is in flight and reports misalignment, bus faults and timeouts.
module mem_lsu_stage
  import orion_types::*;
#(
  parameter int XLEN           = orion_types::XLEN,
  parameter int ADDRW          = orion_types::ADDRW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ex_mem_t           ex_mem_i,
  output logic              stall_o,
  output mem_wb_t           mem_wb_o,
  output mem_id_t           mem_id_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDRW-1:0]  dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  input  logic              dmem_err_i,
  output logic              exc_valid_o,
  output logic [1:0]        exc_cause_o,
  output logic [ADDRW-1:0]  exc_addr_o
);

  localparam int NB   = XLEN / 8;
  localparam int LW   = $clog2(NB);
  localparam int CNTW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  if (XLEN != orion_types::XLEN) begin : g_xlenCheck
    $error("mem_lsu_stage: XLEN parameter differs from orion_types::XLEN");
  end
  if (ADDRW > XLEN) begin : g_addrwCheck
    $error("mem_lsu_stage: ADDRW must not exceed XLEN");
  end

  lsu_state_e      state_q, state_d;
  logic [CNTW-1:0] tmoCnt_q, tmoCnt_d;

  logic            isMem;
  logic            misaligned;
  logic            timeoutHit;
  logic [XLEN-1:0] ldData;
  logic [XLEN-1:0] stWdata;
  logic [NB-1:0]   stBe;

  logic            reqVld;
  logic            stallVld;
  logic            retire;
  logic            excVld;
  logic            fault;
  logic            wbRdWe;
  logic [XLEN-1:0] wbRdV;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (ex_mem_i.ld_str_type),
    .lane_i       (ex_mem_i.rd_v[LW-1:0]),
    .rdata_i      (dmem_rdata_i),
    .stData_i     (ex_mem_i.rs2_v),
    .ldData_o     (ldData),
    .wdata_o      (stWdata),
    .be_o         (stBe),
    .misaligned_o (misaligned)
  );

  assign isMem      = ex_mem_i.valid & (ex_mem_i.is_load | ex_mem_i.is_store);
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (tmoCnt_q == CNTW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= LSU_IDLE;
      tmoCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tmoCnt_q <= tmoCnt_d;
    end
  end

  // EX/MEM is held by stall_o, so the request fields stay stable while waiting for gnt.
  always_comb begin
    state_d  = state_q;
    tmoCnt_d = tmoCnt_q;
    reqVld   = 1'b0;
    stallVld = 1'b0;
    retire   = 1'b0;
    excVld   = 1'b0;
    fault    = 1'b0;
    wbRdWe   = ex_mem_i.rd_we;
    wbRdV    = ex_mem_i.rd_v;
    unique case (state_q)
      LSU_IDLE: begin
        if (isMem) begin
          if (misaligned) begin
            excVld = 1'b1;
            retire = 1'b1;
            wbRdWe = 1'b0;
          end else begin
            reqVld   = 1'b1;
            stallVld = 1'b1;
            tmoCnt_d = '0;
            state_d  = dmem_gnt_i ? LSU_WAIT : LSU_REQ;
          end
        end else begin
          retire = ex_mem_i.valid;
        end
      end
      LSU_REQ: begin
        reqVld   = 1'b1;
        stallVld = 1'b1;
        if (dmem_gnt_i) begin
          tmoCnt_d = '0;
          state_d  = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (dmem_rvalid_i) begin
          retire   = 1'b1;
          tmoCnt_d = '0;
          state_d  = LSU_IDLE;
          if (ex_mem_i.is_load) begin
            wbRdV = ldData;
          end
          if (dmem_err_i) begin
            excVld = 1'b1;
            fault  = 1'b1;
            wbRdWe = 1'b0;
          end
        end else if (timeoutHit) begin
          retire   = 1'b1;
          excVld   = 1'b1;
          fault    = 1'b1;
          wbRdWe   = 1'b0;
          tmoCnt_d = '0;
          state_d  = LSU_IDLE;
        end else begin
          stallVld = 1'b1;
          tmoCnt_d = tmoCnt_q + 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Handshake and retire outputs are forced low while reset is held.
  assign dmem_req_o   = reqVld & ~rst_i;
  assign dmem_we_o    = reqVld & ex_mem_i.is_store & ~rst_i;
  assign dmem_addr_o  = {ex_mem_i.rd_v[ADDRW-1:LW], {LW{1'b0}}};
  assign dmem_be_o    = ex_mem_i.is_store ? stBe : {NB{1'b1}};
  assign dmem_wdata_o = stWdata;
  assign stall_o      = stallVld & ~rst_i;
  assign exc_valid_o  = excVld & ~rst_i;
  assign exc_cause_o  = lsuCause(ex_mem_i.is_load, fault);
  assign exc_addr_o   = ex_mem_i.rd_v[ADDRW-1:0];

  always_comb begin
    mem_wb_o.valid = retire & ~rst_i;
    mem_wb_o.rd_s  = ex_mem_i.rd_s;
    mem_wb_o.rd_we = wbRdWe;
    mem_wb_o.rd_v  = wbRdV;
    mem_wb_o.debug = ex_mem_i.debug;

    mem_id_o.valid = mem_wb_o.valid;
    mem_id_o.rd_we = mem_wb_o.rd_we;
    mem_id_o.rd_s  = mem_wb_o.rd_s;
    mem_id_o.rd_v  = mem_wb_o.rd_v;
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage (XLEN=32, TIMEOUT_CYCLES=4) plus a standalone
// XLEN=64 lsu_align instance for the doubleword / LWU lane cases.
module tb_mem_lsu_stage;
  import orion_types::*;

  logic        clk;
  logic        rst;
  ex_mem_t     exMem;
  logic        stall;
  mem_wb_t     memWb;
  mem_id_t     memId;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata;
  logic        dmemGnt;
  logic        dmemRvalid;
  logic [31:0] dmemRdata;
  logic        dmemErr;
  logic        excValid;
  logic [1:0]  excCause;
  logic [31:0] excAddr;

  logic [2:0]  a64Funct3;
  logic [2:0]  a64Lane;
  logic [63:0] a64Rdata;
  logic [63:0] a64St;
  logic [63:0] a64Ld;
  logic [63:0] a64Wdata;
  logic [7:0]  a64Be;
  logic        a64Mis;

  int total = 0;
  int bad   = 0;

  mem_lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ex_mem_i      (exMem),
    .stall_o       (stall),
    .mem_wb_o      (memWb),
    .mem_id_o      (memId),
    .dmem_req_o    (dmemReq),
    .dmem_we_o     (dmemWe),
    .dmem_addr_o   (dmemAddr),
    .dmem_be_o     (dmemBe),
    .dmem_wdata_o  (dmemWdata),
    .dmem_gnt_i    (dmemGnt),
    .dmem_rvalid_i (dmemRvalid),
    .dmem_rdata_i  (dmemRdata),
    .dmem_err_i    (dmemErr),
    .exc_valid_o   (excValid),
    .exc_cause_o   (excCause),
    .exc_addr_o    (excAddr)
  );

  lsu_align #(.XLEN(64)) u_align64 (
    .funct3_i     (a64Funct3),
    .lane_i       (a64Lane),
    .rdata_i      (a64Rdata),
    .stData_i     (a64St),
    .ldData_o     (a64Ld),
    .wdata_o      (a64Wdata),
    .be_o         (a64Be),
    .misaligned_o (a64Mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        isLoad;
    logic        isStore;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic        expMis;
    logic [1:0]  expCause;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expAddr;
    logic [31:0] expRdV;
    logic        expRdWe;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic isLoad, input logic isStore, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2, input logic gnt);
    exMem             = '0;
    exMem.valid       = 1'b1;
    exMem.is_load     = isLoad;
    exMem.is_store    = isStore;
    exMem.ld_str_type = f3;
    exMem.rd_v        = addr;
    exMem.rs2_v       = rs2;
    exMem.rd_s        = 5'd7;
    exMem.rd_we       = ~isStore;
    exMem.debug.pc    = 32'h0000_1000;
    dmemGnt           = gnt;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"lw",     1, 0, FUNCT3_LS_W,  32'h104, 32'h0,        32'hDEADBEEF, 0, 2'd0, 4'hF,    32'h0,        32'h104, 32'hDEADBEEF, 1};
    vecs[1]  = '{"lb",     1, 0, FUNCT3_LS_B,  32'h103, 32'h0,        32'h80FFFF00, 0, 2'd0, 4'hF,    32'h0,        32'h100, 32'hFFFFFF80, 1};
    vecs[2]  = '{"lbu",    1, 0, FUNCT3_LS_BU, 32'h103, 32'h0,        32'h80FFFF00, 0, 2'd0, 4'hF,    32'h0,        32'h100, 32'h00000080, 1};
    vecs[3]  = '{"sh",     0, 1, FUNCT3_LS_H,  32'h102, 32'h1234ABCD, 32'h0,        0, 2'd0, 4'b1100, 32'hABCDABCD, 32'h100, 32'h00000102, 0};
    vecs[4]  = '{"lh_mis", 1, 0, FUNCT3_LS_H,  32'h101, 32'h0,        32'h0,        1, 2'd0, 4'h0,    32'h0,        32'h0,   32'h00000101, 0};
    vecs[5]  = '{"lh",     1, 0, FUNCT3_LS_H,  32'h102, 32'h0,        32'h80010000, 0, 2'd0, 4'hF,    32'h0,        32'h100, 32'hFFFF8001, 1};
    vecs[6]  = '{"lhu",    1, 0, FUNCT3_LS_HU, 32'h102, 32'h0,        32'h80010000, 0, 2'd0, 4'hF,    32'h0,        32'h100, 32'h00008001, 1};
    vecs[7]  = '{"sb",     0, 1, FUNCT3_LS_B,  32'h101, 32'h000000A5, 32'h0,        0, 2'd0, 4'b0010, 32'hA5A5A5A5, 32'h100, 32'h00000101, 0};
    vecs[8]  = '{"sw_mis", 0, 1, FUNCT3_LS_W,  32'h106, 32'h0,        32'h0,        1, 2'd1, 4'h0,    32'h0,        32'h0,   32'h00000106, 0};
    vecs[9]  = '{"lw_mis", 1, 0, FUNCT3_LS_W,  32'h10A, 32'h0,        32'h0,        1, 2'd0, 4'h0,    32'h0,        32'h0,   32'h0000010A, 0};
    vecs[10] = '{"sw",     0, 1, FUNCT3_LS_W,  32'h108, 32'hCAFEF00D, 32'h0,        0, 2'd0, 4'hF,    32'hCAFEF00D, 32'h108, 32'h00000108, 0};
    vecs[11] = '{"lb_pos", 1, 0, FUNCT3_LS_B,  32'h100, 32'h0,        32'h0000007F, 0, 2'd0, 4'hF,    32'h0,        32'h100, 32'h0000007F, 1};
    vecs[12] = '{"alu",    0, 0, FUNCT3_LS_W,  32'h55,  32'h0,        32'h0,        0, 2'd0, 4'h0,    32'h0,        32'h0,   32'h00000055, 1};

    rst        = 1'b1;
    dmemRvalid = 1'b0;
    dmemRdata  = '0;
    dmemErr    = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 1'b0);
    a64Funct3 = FUNCT3_LS_D;
    a64Lane   = 3'd0;
    a64Rdata  = 64'hF000_0000_0000_0000;
    a64St     = 64'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_req", dmemReq, 0);
    checkOutput("rst_exc", excValid, 0);
    checkOutput("rst_wbvalid", memWb.valid, 0);
    checkOutput("rst_idvalid", memId.valid, 0);
    rst = 1'b0;
    nextCycle();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].isLoad, vecs[i].isStore, vecs[i].f3, vecs[i].addr, vecs[i].rs2, 1'b1);
      #2;
      if (!vecs[i].isLoad && !vecs[i].isStore) begin
        checkOutput({vecs[i].name, "_stall"}, stall, 0);
        checkOutput({vecs[i].name, "_req"}, dmemReq, 0);
        checkOutput({vecs[i].name, "_wbvalid"}, memWb.valid, 1);
        checkOutput({vecs[i].name, "_rdv"}, memWb.rd_v, vecs[i].expRdV);
        checkOutput({vecs[i].name, "_rdwe"}, memWb.rd_we, vecs[i].expRdWe);
      end else if (vecs[i].expMis) begin
        checkOutput({vecs[i].name, "_req"}, dmemReq, 0);
        checkOutput({vecs[i].name, "_stall"}, stall, 0);
        checkOutput({vecs[i].name, "_exc"}, excValid, 1);
        checkOutput({vecs[i].name, "_cause"}, excCause, vecs[i].expCause);
        checkOutput({vecs[i].name, "_excaddr"}, excAddr, vecs[i].addr);
        checkOutput({vecs[i].name, "_wbvalid"}, memWb.valid, 1);
        checkOutput({vecs[i].name, "_rdwe"}, memWb.rd_we, 0);
      end else begin
        checkOutput({vecs[i].name, "_req"}, dmemReq, 1);
        checkOutput({vecs[i].name, "_we"}, dmemWe, vecs[i].isStore);
        checkOutput({vecs[i].name, "_stall"}, stall, 1);
        checkOutput({vecs[i].name, "_wbvalid0"}, memWb.valid, 0);
        checkOutput({vecs[i].name, "_addr"}, dmemAddr, vecs[i].expAddr);
        checkOutput({vecs[i].name, "_be"}, dmemBe, vecs[i].expBe);
        if (vecs[i].isStore) begin
          checkOutput({vecs[i].name, "_wdata"}, dmemWdata, vecs[i].expWdata);
        end
        nextCycle();
        dmemGnt    = 1'b0;
        dmemRvalid = 1'b1;
        dmemRdata  = vecs[i].rdata;
        #2;
        checkOutput({vecs[i].name, "_rsp_stall"}, stall, 0);
        checkOutput({vecs[i].name, "_rsp_wbvalid"}, memWb.valid, 1);
        checkOutput({vecs[i].name, "_rsp_exc"}, excValid, 0);
        checkOutput({vecs[i].name, "_rsp_rdv"}, memWb.rd_v, vecs[i].expRdV);
        checkOutput({vecs[i].name, "_rsp_idrdv"}, memId.rd_v, vecs[i].expRdV);
        checkOutput({vecs[i].name, "_rsp_rdwe"}, memWb.rd_we, vecs[i].expRdWe);
      end
      nextCycle();
      dmemRvalid = 1'b0;
      dmemGnt    = 1'b0;
      exMem.valid = 1'b0;
    end

    // SW with gnt withheld three cycles, a stray rvalid while in REQ, then an error response.
    applyStimulus(1'b0, 1'b1, FUNCT3_LS_W, 32'h200, 32'h11223344, 1'b0);
    for (int c = 0; c < 3; c++) begin
      dmemRvalid = (c == 1);
      #2;
      checkOutput($sformatf("hold%0d_req", c), dmemReq, 1);
      checkOutput($sformatf("hold%0d_addr", c), dmemAddr, 32'h200);
      checkOutput($sformatf("hold%0d_wdata", c), dmemWdata, 32'h11223344);
      checkOutput($sformatf("hold%0d_stall", c), stall, 1);
      checkOutput($sformatf("hold%0d_wbvalid", c), memWb.valid, 0);
      nextCycle();
    end
    dmemRvalid = 1'b0;
    dmemGnt    = 1'b1;
    #2;
    checkOutput("hold_gnt_req", dmemReq, 1);
    nextCycle();
    dmemGnt    = 1'b0;
    dmemRvalid = 1'b1;
    dmemErr    = 1'b1;
    #2;
    checkOutput("sterr_exc", excValid, 1);
    checkOutput("sterr_cause", excCause, 2'd3);
    checkOutput("sterr_stall", stall, 0);
    checkOutput("sterr_wbvalid", memWb.valid, 1);
    checkOutput("sterr_rdwe", memWb.rd_we, 0);
    nextCycle();
    dmemRvalid  = 1'b0;
    dmemErr     = 1'b0;
    exMem.valid = 1'b0;

    // Load that never gets a response: four stall cycles, then a load-fault timeout.
    applyStimulus(1'b1, 1'b0, FUNCT3_LS_W, 32'h300, 32'h0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #2;
      checkOutput($sformatf("tmo%0d_stall", c), stall, 1);
      checkOutput($sformatf("tmo%0d_exc", c), excValid, 0);
      checkOutput($sformatf("tmo%0d_wbvalid", c), memWb.valid, 0);
      nextCycle();
      dmemGnt = 1'b0;
    end
    #2;
    checkOutput("tmo_stall", stall, 0);
    checkOutput("tmo_exc", excValid, 1);
    checkOutput("tmo_cause", excCause, 2'd2);
    checkOutput("tmo_wbvalid", memWb.valid, 1);
    checkOutput("tmo_rdwe", memWb.rd_we, 0);
    nextCycle();
    exMem.valid = 1'b0;
    dmemRvalid  = 1'b1;
    dmemRdata   = 32'h12345678;
    #2;
    checkOutput("late_wbvalid", memWb.valid, 0);
    checkOutput("late_exc", excValid, 0);
    checkOutput("late_stall", stall, 0);
    nextCycle();
    dmemRvalid = 1'b0;

    // Reset asserted while an access waits for its response.
    applyStimulus(1'b1, 1'b0, FUNCT3_LS_W, 32'h104, 32'h0, 1'b1);
    nextCycle();
    dmemGnt = 1'b0;
    #2;
    checkOutput("wait_stall", stall, 1);
    checkOutput("wait_req", dmemReq, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_req", dmemReq, 0);
    checkOutput("midrst_exc", excValid, 0);
    checkOutput("midrst_wbvalid", memWb.valid, 0);
    checkOutput("midrst_idvalid", memId.valid, 0);
    nextCycle();
    rst = 1'b0;
    #2;
    checkOutput("postrst_req", dmemReq, 1);
    checkOutput("postrst_stall", stall, 1);
    nextCycle();
    exMem.valid = 1'b0;

    a64Funct3 = FUNCT3_LS_D;
    a64Lane   = 3'd0;
    #1;
    checkOutput("x64_ld", a64Ld, 64'hF000_0000_0000_0000);
    checkOutput("x64_ld_mis", a64Mis, 0);
    checkOutput("x64_sd_be", a64Be, 8'hFF);
    a64Funct3 = FUNCT3_LS_WU;
    a64Lane   = 3'd4;
    #1;
    checkOutput("x64_lwu", a64Ld, 64'h0000_0000_F000_0000);
    a64Funct3 = FUNCT3_LS_W;
    #1;
    checkOutput("x64_lw", a64Ld, 64'hFFFF_FFFF_F000_0000);
    a64Funct3 = FUNCT3_LS_D;
    #1;
    checkOutput("x64_ld_mis4", a64Mis, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
